// File: rtl/multiport_register_file.sv
// Register file with one write port, two registered read ports and a
// sweep-clear controller that zeroes one register per cycle.
module multiport_register_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_enable,
    input  logic [$clog2(DEPTH)-1:0]     write_address,
    input  logic [WIDTH-1:0]             write_data,
    input  logic [$clog2(DEPTH)-1:0]     read_address_a,
    input  logic [$clog2(DEPTH)-1:0]     read_address_b,
    output logic [WIDTH-1:0]             read_data_a,
    output logic [WIDTH-1:0]             read_data_b,
    input  logic                         clear_all_start,
    output logic                         busy,
    output logic                         clear_done
);

    // state | meaning
    // IDLE  | normal writes accepted; clear_all_start launches a sweep
    // CLEAR | zeroing register[index] each cycle, writes dropped
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] INDEX_LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     index_q, index_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [WIDTH-1:0]  read_data_a_q, read_data_a_d;
    logic [WIDTH-1:0]  read_data_b_q, read_data_b_d;
    logic              busy_q, busy_d;
    logic              clear_done_q, clear_done_d;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        regs_d       = regs_q;
        clear_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (write_enable) begin
                    regs_d[write_address] = write_data;
                end
                if (clear_all_start) begin
                    state_d = CLEAR;
                    index_d = '0;
                end
            end
            CLEAR: begin
                regs_d[index_q] = '0;
                index_d         = index_q + 1'b1;
                if (index_q == INDEX_LAST) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
        busy_d = (state_d == CLEAR);
        // Reading the post-update array gives write-first and clear bypass.
        read_data_a_d = regs_d[read_address_a];
        read_data_b_d = regs_d[read_address_b];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            index_q       <= '0;
            read_data_a_q <= '0;
            read_data_b_q <= '0;
            busy_q        <= 1'b0;
            clear_done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            read_data_a_q <= read_data_a_d;
            read_data_b_q <= read_data_b_d;
            busy_q        <= busy_d;
            clear_done_q  <= clear_done_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign read_data_a = read_data_a_q;
    assign read_data_b = read_data_b_q;
    assign busy        = busy_q;
    assign clear_done  = clear_done_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench: three configurations share one stimulus bus; expected
// values are queued per cycle and checked by a negedge monitor.
module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  wa = '0;
    logic [15:0] wd = '0;
    logic [2:0]  ra = '0;
    logic [2:0]  rb = '0;
    logic        cs = 1'b0;

    logic [7:0]  d0_rda, d0_rdb, d1_rda, d1_rdb;
    logic [15:0] d2_rda, d2_rdb;
    logic        d0_busy, d0_done, d1_busy, d1_done, d2_busy, d2_done;

    always #5 clk = ~clk;

    multiport_register_file #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset), .write_enable(we), .write_address(wa[1:0]),
        .write_data(wd[7:0]), .read_address_a(ra[1:0]), .read_address_b(rb[1:0]),
        .read_data_a(d0_rda), .read_data_b(d0_rdb), .clear_all_start(cs),
        .busy(d0_busy), .clear_done(d0_done));

    multiport_register_file #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .write_enable(we), .write_address(wa[1:0]),
        .write_data(wd[7:0]), .read_address_a(ra[1:0]), .read_address_b(rb[1:0]),
        .read_data_a(d1_rda), .read_data_b(d1_rdb), .clear_all_start(cs),
        .busy(d1_busy), .clear_done(d1_done));

    multiport_register_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut2 (
        .clk(clk), .reset(reset), .write_enable(we), .write_address(wa),
        .write_data(wd), .read_address_a(ra), .read_address_b(rb),
        .read_data_a(d2_rda), .read_data_b(d2_rdb), .clear_all_start(cs),
        .busy(d2_busy), .clear_done(d2_done));

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    localparam int S_D0A = 0, S_D0B = 1, S_D0BUSY = 2, S_D0DONE = 3;
    localparam int S_D1A = 4, S_D1B = 5, S_D2A = 6, S_D2B = 7;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pick(int sel);
        case (sel)
            S_D0A:    return {8'h00, d0_rda};
            S_D0B:    return {8'h00, d0_rdb};
            S_D0BUSY: return {15'h0, d0_busy};
            S_D0DONE: return {15'h0, d0_done};
            S_D1A:    return {8'h00, d1_rda};
            S_D1B:    return {8'h00, d1_rdb};
            S_D2A:    return d2_rda;
            S_D2B:    return d2_rdb;
            default:  return 16'hxxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = pick(e.sel);
            n_tests++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_next(int sel, logic [15:0] val, string name);
        exp_t e;
        e.cyc = cyc + 1;
        e.sel = sel;
        e.val = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic wr(logic [2:0] a, logic [15:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        expect_next(S_D0A, 16'h0, "reset_rda");
        expect_next(S_D0B, 16'h0, "reset_rdb");
        expect_next(S_D0BUSY, 16'h0, "reset_busy");
        expect_next(S_D0DONE, 16'h0, "reset_done");
        tick();
        reset = 1'b0;

        // basic write then dual read
        wr(3'd0, 16'h00FF);
        tick();
        wr(3'd1, 16'h00AA);
        tick();
        we = 1'b0; ra = 3'd0; rb = 3'd1;
        expect_next(S_D0A, 16'h00FF, "rd_r0");
        expect_next(S_D0B, 16'h00AA, "rd_r1");
        expect_next(S_D1A, 16'h0000, "zreg_r0_stored");
        expect_next(S_D1B, 16'h00AA, "zreg_r1_stored");
        tick();

        // write bypass, both ports same address
        wr(3'd2, 16'h005C); ra = 3'd2; rb = 3'd2;
        expect_next(S_D0A, 16'h005C, "bypass_a");
        expect_next(S_D0B, 16'h005C, "bypass_b");
        tick();

        // ZERO_REG bypass suppressed, r1 unaffected
        wr(3'd0, 16'h0033); ra = 3'd0; rb = 3'd1;
        expect_next(S_D1A, 16'h0000, "zreg_bypass");
        expect_next(S_D1B, 16'h00AA, "zreg_r1");
        expect_next(S_D0A, 16'h0033, "nozreg_bypass");
        tick();
        we = 1'b0;
        expect_next(S_D1A, 16'h0000, "zreg_hold");
        expect_next(S_D0A, 16'h0033, "nozreg_hold");
        tick();

        // wide configuration, top register
        wr(3'd7, 16'hBEEF); ra = 3'd7; rb = 3'd7;
        expect_next(S_D2A, 16'hBEEF, "wide_bypass_a");
        expect_next(S_D2B, 16'hBEEF, "wide_bypass_b");
        tick();
        we = 1'b0;
        expect_next(S_D2A, 16'hBEEF, "wide_stored_a");
        expect_next(S_D2B, 16'hBEEF, "wide_stored_b");
        expect_next(S_D0A, 16'h00EF, "d0_r3_alias");
        tick();

        // dut0 now r0=33 r1=AA r2=5C r3=EF; full sweep
        cs = 1'b1; ra = 3'd0; rb = 3'd2;
        expect_next(S_D0BUSY, 16'h1, "sweep_enter_busy");
        expect_next(S_D0DONE, 16'h0, "sweep_enter_done");
        expect_next(S_D0A, 16'h0033, "sweep_enter_rda");
        expect_next(S_D0B, 16'h005C, "sweep_enter_rdb");
        tick();
        cs = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr(3'd3, 16'h0077);
            ra = 3'(k); rb = 3'd3;
            expect_next(S_D0A, 16'h0000, "sweep_clear_bypass");
            expect_next(S_D0B, (k == 3) ? 16'h0000 : 16'h00EF, "sweep_r3_write_dropped");
            expect_next(S_D0BUSY, (k == 3) ? 16'h0 : 16'h1, "sweep_busy");
            expect_next(S_D0DONE, (k == 3) ? 16'h1 : 16'h0, "sweep_done");
            tick();
        end
        we = 1'b0; ra = 3'd0; rb = 3'd1;
        expect_next(S_D0DONE, 16'h0, "done_one_cycle");
        expect_next(S_D0BUSY, 16'h0, "idle_busy");
        expect_next(S_D0A, 16'h0, "cleared_r0");
        expect_next(S_D0B, 16'h0, "cleared_r1");
        tick();
        ra = 3'd2; rb = 3'd3;
        expect_next(S_D0A, 16'h0, "cleared_r2");
        expect_next(S_D0B, 16'h0, "cleared_r3");
        tick();
        for (int k = 0; k < 4; k++) tick();

        // restart request mid-sweep must not extend it
        wr(3'd1, 16'h0011);
        tick();
        we = 1'b0; cs = 1'b1;
        expect_next(S_D0BUSY, 16'h1, "restart_enter");
        tick();
        for (int k = 0; k < 4; k++) begin
            cs = (k == 2);
            expect_next(S_D0BUSY, (k == 3) ? 16'h0 : 16'h1, "restart_busy");
            expect_next(S_D0DONE, (k == 3) ? 16'h1 : 16'h0, "restart_done");
            tick();
        end
        cs = 1'b0;
        expect_next(S_D0BUSY, 16'h0, "restart_idle");
        expect_next(S_D0DONE, 16'h0, "restart_done_low");
        tick();
        for (int k = 0; k < 4; k++) tick();

        // reset mid-sweep aborts without clear_done
        wr(3'd2, 16'h0022);
        tick();
        wr(3'd3, 16'h0044);
        tick();
        we = 1'b0; cs = 1'b1;
        tick();
        cs = 1'b0; ra = 3'd3;
        expect_next(S_D0A, 16'h0044, "pre_reset_r3");
        tick();
        tick();
        reset = 1'b1; ra = 3'd2; rb = 3'd3;
        expect_next(S_D0BUSY, 16'h0, "abort_busy");
        expect_next(S_D0DONE, 16'h0, "abort_done");
        expect_next(S_D0A, 16'h0, "abort_rda");
        expect_next(S_D0B, 16'h0, "abort_rdb");
        tick();
        reset = 1'b0;
        expect_next(S_D0A, 16'h0, "post_reset_r2");
        expect_next(S_D0B, 16'h0, "post_reset_r3");
        expect_next(S_D0DONE, 16'h0, "post_reset_no_done");
        tick();
        expect_next(S_D0DONE, 16'h0, "post_reset_no_done2");
        expect_next(S_D0BUSY, 16'h0, "post_reset_busy");
        tick();
        tick();
        tick();

        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the register count; legal values are powers of two, at least 2.
REQ-004 Parameter ZERO_REG, default 0, SHALL, when 1, make register 0 read as zero and ignore writes to it.
REQ-005 AW SHALL be derived internally as clog2(DEPTH) and SHALL NOT be user-settable.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 write_enable  in  1  write request for the current cycle.
REQ-009 write_address  in  AW  target register for the write.
REQ-010 write_data  in  WIDTH  data to write.
REQ-011 read_address_a  in  AW  read port A address.
REQ-012 read_address_b  in  AW  read port B address.
REQ-013 read_data_a  out  WIDTH  registered read port A data.
REQ-014 read_data_b  out  WIDTH  registered read port B data.
REQ-015 clear_all_start  in  1  request to sweep-clear all registers.
REQ-016 busy  out  1  high while the clear sweep runs.
REQ-017 clear_done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-018 Storage SHALL be DEPTH registers of WIDTH bits, updated only on rising edges of clk.
REQ-019 The controller SHALL have two states, IDLE and CLEAR, plus an AW-bit sweep index.
REQ-020 In IDLE with write_enable=1, register[write_address] SHALL take write_data at the edge.
REQ-021 In CLEAR, write_enable SHALL be ignored and no write occurs.
REQ-022 IDLE to CLEAR: on an edge in IDLE with clear_all_start=1, the block SHALL enter CLEAR with index=0.
REQ-023 A write present in that same IDLE cycle SHALL still be performed.
REQ-024 In CLEAR, each edge SHALL zero register[index] and increment index.
REQ-025 CLEAR to IDLE: on the edge that clears index DEPTH-1, the block SHALL return to IDLE; CLEAR therefore lasts exactly DEPTH cycles.
REQ-026 busy SHALL be 1 exactly while the state is CLEAR.
REQ-027 clear_done SHALL be 1 for exactly the one cycle following the return to IDLE.
REQ-028 clear_all_start SHALL be ignored while in CLEAR; it SHALL NOT restart or extend the sweep.
REQ-029 Each read port SHALL register, at every edge, the value its addressed register holds after that edge's update (write-first); read latency is one cycle.
REQ-030 A same-cycle write to a read address SHALL be bypassed: read_data returns write_data on the next cycle.
REQ-031 A same-cycle clear of a read address SHALL be bypassed: read_data returns 0 on the next cycle.
REQ-032 Ports A and B SHALL be fully independent and MAY use the same address, returning identical data.
REQ-033 With ZERO_REG=1, reads of address 0 SHALL return 0, including the write-bypass case.
REQ-034 Reads SHALL operate normally in both IDLE and CLEAR.

Reset
REQ-035 reset SHALL override all other inputs on the edge where it is sampled high.
REQ-036 That edge SHALL zero all registers, read_data_a, read_data_b, busy, clear_done and index, and set the state to IDLE.
REQ-037 A reset mid-sweep SHALL abort the sweep with no clear_done pulse.

Verification
REQ-038 Reset, write 0xFF to r0 and 0xAA to r1, read A=0, B=1 -> next cycle A=0xFF, B=0xAA.
REQ-039 Write 0x5C to r2 while A=2 in the same cycle -> A=0x5C on the next cycle (bypass).
REQ-040 DEPTH=4, registers preloaded, clear_all_start pulse -> busy high 4 cycles, then clear_done for 1 cycle, all reads 0; writes during busy dropped.
REQ-041 Restart plus reset mid-sweep: clear_all_start reasserted at sweep cycle 2 -> sweep still ends after 4 cycles; separately, reset at sweep cycle 2 -> busy=0, no clear_done, all registers 0.
REQ-042 ZERO_REG=1, write 0x33 to r0 and read r0 in the same cycle -> read 0x00; r1 unaffected.
REQ-043 WIDTH=16, DEPTH=8: write 0xBEEF to r7, read A=7, B=7 -> both ports return 0xBEEF.
